// File: rtl/mmio_gpio_responder.sv
// mmio_gpio_responder
//   Memory-mapped GPIO target on the CPU data bus. It decodes a 16-byte window at
//   BASE_ADDR and exposes four word registers:
//     0x0 LED  RW   [15:0] drives the board LEDs
//     0x4 SW   RO   debounced switch state
//     0x8 CHG  RW1C sticky per-bit change flags of the debounced switches
//     0xC ID   RO   constant 32'h4750_494F
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous active-low reset
//     req        access request, held high by the CPU until it sees ack
//     we         1 = store, 0 = load (valid while req)
//     addr       byte address (valid while req)
//     be         byte-lane enables
//     wdata      lane-aligned store data
//     rdata      load data, valid with ack, 0 otherwise
//     ack        one-cycle access-complete pulse
//     err        qualifies ack: misaligned access
//     sw         raw asynchronous board switches
//     led        board LEDs
//     state_dbg  current handshake FSM state (0 IDLE, 1 ACK, 2 WAIT)
//
//   Handshake: an access is performed on the clock edge where the FSM is IDLE and
//   req is high with an address in the window. ack is high for exactly the next
//   cycle. The FSM then waits for req to drop, so a single request (however long it
//   is held) is serviced exactly once. Requests outside the window are ignored.
module mmio_gpio_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter logic [19:0] DEBOUNCE_CYCS = 20'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCS - 20'd1);
  localparam logic [31:0] ID_VALUE = 32'h4750_494F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;
  logic [15:0] led_q, led_d;
  logic [15:0] chg_q, chg_d;
  logic [15:0] sync1_q, sync2_q, stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Access decode
  logic        hit, be_onehot, misaligned, do_access, do_store;
  logic [15:0] lane_mask, chg_set, chg_clr;
  logic [31:0] rd_word;
  logic        deb_fire;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
  assign be_onehot  = (be != 4'd0) && ((be & (be - 4'd1)) == 4'd0);
  assign misaligned = (addr[1:0] != 2'd0) && !be_onehot;
  assign do_access  = (state_q == ST_IDLE) && req && hit;
  assign do_store   = do_access && we && !misaligned;
  // Only lanes 0 and 1 carry register bits; lanes 2 and 3 have nothing behind them.
  assign lane_mask  = {{8{be[1]}}, {8{be[0]}}};

  always_comb begin
    rd_word = 32'd0;
    case (addr[3:2])
      2'd0: rd_word = {16'd0, led_q};
      2'd1: rd_word = {16'd0, stable_q};
      2'd2: rd_word = {16'd0, chg_q};
      2'd3: rd_word = ID_VALUE;
      default: rd_word = 32'd0;
    endcase
  end

  // Debounce acceptance: one shared counter for all bits; any difference between the
  // synchronised and stable vectors must persist DEBOUNCE_CYCS cycles.
  assign deb_fire = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
  assign chg_set  = deb_fire ? (sync2_q ^ stable_q) : 16'd0;
  assign chg_clr  = (do_store && addr[3:2] == 2'd2) ? (wdata[15:0] & lane_mask) : 16'd0;
  // A set arriving in the same cycle as a clear of the same bit must survive.
  assign chg_d    = (chg_q & ~chg_clr) | chg_set;

  always_comb begin
    led_d = led_q;
    if (do_store && addr[3:2] == 2'd0) begin
      if (be[0]) led_d[7:0]  = wdata[7:0];
      if (be[1]) led_d[15:8] = wdata[15:8];
    end
  end

  // Handshake FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= 16'd0;
    end else begin
      led_q <= led_d;
      case (state_q)
        ST_IDLE: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          if (do_access) begin
            ack_q   <= 1'b1;
            err_q   <= misaligned;
            rdata_q <= (we || misaligned) ? 32'd0 : rd_word;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!req) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Switch synchroniser, debounce counter and change flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 16'd0;
      sync2_q  <= 16'd0;
      stable_q <= 16'd0;
      cnt_q    <= '0;
      chg_q    <= 16'd0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      chg_q   <= chg_d;
      if (sync2_q != stable_q) begin
        if (deb_fire) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign led       = led_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mmio_gpio_responder.sv
// tb_mmio_gpio_responder
//   Directed bench for mmio_gpio_responder with DEBOUNCE_CYCS = 4. Inputs are driven
//   1 time unit after the rising edge and outputs are sampled at the same point, away
//   from the active edge.
module tb_mmio_gpio_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic [15:0] sw;
  logic [15:0] led;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_gpio_responder #(
    .BASE_ADDR    (32'h8000_0000),
    .DEBOUNCE_CYCS(20'd4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .be       (be),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .err      (err),
    .sw       (sw),
    .led      (led),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one complete request. lat = cycles from request to ack (0 = timeout).
  // Leaves the bench 1 unit after an edge with the responder back in IDLE.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    lat = 0; rd = 32'hDEAD_BEEF; e = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0; sw = 16'd0;
    #12;
    n_checks++;
    if ({rdata, ack, err, led, state_dbg} !== {32'd0, 1'b0, 1'b0, 16'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: rdata=%h ack=%b err=%b led=%h st=%0d, expected all 0",
               rdata, ack, err, led, state_dbg);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_led_word();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 32'h8000_0000, 4'hF, 32'h0000_007B, rd, e, lat);
    n_checks++;
    if (lat !== 1 || e !== 1'b0 || led !== 16'h007B) begin
      n_fail++;
      $display("FAIL led_store: lat=%0d err=%b led=%h, expected lat=1 err=0 led=007b", lat, e, led);
    end
    access(1'b0, 32'h8000_0000, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (lat !== 1 || e !== 1'b0 || rd !== 32'h0000_007B) begin
      n_fail++;
      $display("FAIL led_load: lat=%0d err=%b rdata=%h, expected 1 0 0000007b", lat, e, rd);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 32'h8000_0001, 4'b0010, 32'h0000_FF00, rd, e, lat);
    n_checks++;
    if (e !== 1'b0 || led !== 16'hFF7B) begin
      n_fail++;
      $display("FAIL led_sb: err=%b led=%h, expected err=0 led=ff7b", e, led);
    end
    access(1'b1, 32'h8000_0000, 4'b0011, 32'h0000_0214, rd, e, lat);
    n_checks++;
    if (e !== 1'b0 || led !== 16'h0214) begin
      n_fail++;
      $display("FAIL led_sh: err=%b led=%h, expected err=0 led=0214", e, led);
    end
    // Upper lanes hold no LED bits.
    access(1'b1, 32'h8000_0000, 4'b1100, 32'hFFFF_FFFF, rd, e, lat);
    n_checks++;
    if (e !== 1'b0 || led !== 16'h0214) begin
      n_fail++;
      $display("FAIL led_upper_lanes: err=%b led=%h, expected err=0 led=0214", e, led);
    end
  endtask

  task automatic test_switch();
    logic [31:0] rd; logic e; int lat;
    sw = 16'h0005;
    repeat (8) @(posedge clk);
    #1;
    access(1'b0, 32'h8000_0004, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL sw_debounced: rdata=%h, expected 00000005", rd);
    end
    access(1'b0, 32'h8000_0008, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL chg_after_sw: rdata=%h, expected 00000005", rd);
    end
    // Two-cycle glitch must be rejected.
    sw = 16'h0007;
    repeat (2) @(posedge clk);
    #1; sw = 16'h0005;
    repeat (8) @(posedge clk);
    #1;
    access(1'b0, 32'h8000_0004, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL sw_glitch: rdata=%h, expected 00000005", rd);
    end
    access(1'b0, 32'h8000_0008, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL chg_glitch: rdata=%h, expected 00000005", rd);
    end
    // Stores to SW are acked cleanly and ignored.
    access(1'b1, 32'h8000_0004, 4'hF, 32'h0000_FFFF, rd, e, lat);
    n_checks++;
    if (lat !== 1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_store_ack: lat=%0d err=%b, expected 1 0", lat, e);
    end
    access(1'b0, 32'h8000_0004, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL sw_store_noeffect: rdata=%h, expected 00000005", rd);
    end
  endtask

  task automatic test_chg_clear();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 32'h8000_0008, 4'hF, 32'h0000_0001, rd, e, lat);
    access(1'b0, 32'h8000_0008, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL chg_w1c: rdata=%h, expected 00000004", rd);
    end
    // sw bit0 falls now; the debounced update lands on the 6th following edge,
    // which is the edge that samples the clearing store of bits 0 and 2.
    sw = 16'h0004;
    repeat (5) @(posedge clk);
    #1;
    access(1'b1, 32'h8000_0008, 4'hF, 32'h0000_0005, rd, e, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL chg_race_lat: lat=%0d, expected 1", lat);
    end
    access(1'b0, 32'h8000_0008, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL chg_set_wins: rdata=%h, expected 00000001", rd);
    end
    access(1'b0, 32'h8000_0004, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL sw_after_race: rdata=%h, expected 00000004", rd);
    end
  endtask

  task automatic test_decode();
    logic [31:0] rd; logic e; int lat; int acks;
    req = 1'b1; we = 1'b0; addr = 32'h9000_0000; be = 4'hF;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL unmapped_no_ack: acks=%0d, expected 0", acks);
    end
    access(1'b0, 32'h8000_0002, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL misaligned_load: lat=%0d err=%b rdata=%h, expected 1 1 00000000", lat, e, rd);
    end
    access(1'b1, 32'h8000_0001, 4'hF, 32'h0000_0000, rd, e, lat);
    n_checks++;
    if (e !== 1'b1 || led !== 16'h0214) begin
      n_fail++;
      $display("FAIL misaligned_store: err=%b led=%h, expected 1 0214", e, led);
    end
    access(1'b0, 32'h8000_0001, 4'b0010, 32'd0, rd, e, lat);
    n_checks++;
    if (e !== 1'b0 || rd !== 32'h0000_0214) begin
      n_fail++;
      $display("FAIL byte_load_off1: err=%b rdata=%h, expected 0 00000214", e, rd);
    end
    access(1'b0, 32'h8000_000C, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (e !== 1'b0 || rd !== 32'h4750_494F) begin
      n_fail++;
      $display("FAIL id_load: err=%b rdata=%h, expected 0 4750494f", e, rd);
    end
  endtask

  task automatic test_held_request();
    int acks;
    req = 1'b1; we = 1'b0; addr = 32'h8000_0000; be = 4'hF;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      else if (rdata !== 32'd0) begin
        n_checks++; n_fail++;
        $display("FAIL rdata_idle_zero: rdata=%h, expected 00000000", rdata);
      end
    end
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL held_req_one_ack: acks=%0d, expected 1", acks);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat;
    sw = 16'h0000;
    req = 1'b1; we = 1'b0; addr = 32'h8000_0000; be = 4'hF;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1 || rdata !== 32'h0000_0214) begin
      n_fail++;
      $display("FAIL pre_reset_ack: ack=%b rdata=%h, expected 1 00000214", ack, rdata);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ack !== 1'b0 || led !== 16'd0 || state_dbg !== 2'd0 || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: ack=%b led=%h st=%0d rdata=%h, expected 0 0000 0 0",
               ack, led, state_dbg, rdata);
    end
    #1; rst = 1'b1;
    // The still-held request is serviced again as a new one.
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = i; break; end
    end
    n_checks++;
    if (lat !== 1 || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL held_after_reset: lat=%0d rdata=%h, expected 1 00000000", lat, rdata);
    end
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    access(1'b0, 32'h8000_0008, 4'hF, 32'd0, rd, e, lat);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL chg_after_reset: rdata=%h, expected 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_led_word();
    test_byte_half();
    test_switch();
    test_chg_clear();
    test_decode();
    test_held_request();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
